// File: rtl/fetch_prefetch_q_if.sv
// Fetch-stage bus: the memory-side syn/ack request channel plus the
// decode-side queue head, redirect and flush controls, bundled so the
// fetch stage and its environment connect through one port.
interface fetch_prefetch_q_if #(
    parameter int IWIDTH       = 32,
    parameter int AWIDTH_INSTR = 32,
    parameter int PC_WIDTH     = 32,
    parameter int QDEPTH       = 4
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    // Pipeline control from execute / decode
    logic                    fi_i_ce;
    logic                    fi_change_pc;
    logic [PC_WIDTH-1:0]     fi_alu_pc_value;
    logic                    fi_i_flush;
    logic                    fi_i_stall;

    // Instruction-memory request channel
    logic                    fi_o_syn;
    logic [AWIDTH_INSTR-1:0] fi_o_req_addr;
    logic                    fi_i_ack;
    logic [IWIDTH-1:0]       fi_i_instr;

    // Queue head presented to decode, plus status
    logic [IWIDTH-1:0]       fi_o_instr_fetch;
    logic [AWIDTH_INSTR-1:0] fi_o_addr_instr;
    logic                    fi_o_ce;
    logic [PC_WIDTH-1:0]     fi_pc;
    logic                    fi_o_flush;
    logic [CNT_W-1:0]        fi_o_count;

    // The fetch stage itself
    modport master (
        input  fi_i_ce, fi_change_pc, fi_alu_pc_value, fi_i_flush, fi_i_stall,
        input  fi_i_ack, fi_i_instr,
        output fi_o_syn, fi_o_req_addr,
        output fi_o_instr_fetch, fi_o_addr_instr, fi_o_ce, fi_pc, fi_o_flush, fi_o_count
    );

    // Memory plus decode, seen from outside the fetch stage
    modport slave (
        output fi_i_ce, fi_change_pc, fi_alu_pc_value, fi_i_flush, fi_i_stall,
        output fi_i_ack, fi_i_instr,
        input  fi_o_syn, fi_o_req_addr,
        input  fi_o_instr_fetch, fi_o_addr_instr, fi_o_ce, fi_pc, fi_o_flush, fi_o_count
    );
endinterface

// File: rtl/fetch_prefetch_q.sv
// Successor fetch stage: PC generator, syn/ack instruction-memory master and
// a QDEPTH-entry prefetch queue. A request is only issued when a queue slot
// is guaranteed free for its reply, so the queue can never overflow. Redirect
// and flush clear the queue; an in-flight request is then waited out in DROP
// and its data thrown away.
module fetch_prefetch_q #(
    parameter int                  IWIDTH       = 32,
    parameter int                  AWIDTH_INSTR = 32,
    parameter int                  PC_WIDTH     = 32,
    parameter int                  QDEPTH       = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic               fi_clk,
    input  logic               fi_rst,
    fetch_prefetch_q_if.master fi_bus
);
    localparam int                  PTR_W   = $clog2(QDEPTH);
    localparam int                  CNT_W   = PTR_W + 1;
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(IWIDTH / 8);
    localparam logic [CNT_W-1:0]    DEPTH   = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_syn;
    logic [AWIDTH_INSTR-1:0] r_reqAddr;
    logic [PC_WIDTH-1:0]     r_pc;
    logic                    r_flushDly;

    logic [IWIDTH-1:0]       r_instrMem [QDEPTH];
    logic [AWIDTH_INSTR-1:0] r_addrMem  [QDEPTH];
    logic [PTR_W-1:0]        r_rdPtr;
    logic [PTR_W-1:0]        r_wrPtr;
    logic [CNT_W-1:0]        r_count;

    logic                    w_redirect;
    logic                    w_clear;
    logic                    w_ack;
    logic                    w_notEmpty;
    logic                    w_push;
    logic                    w_pop;
    logic [CNT_W-1:0]        w_countNext;
    logic                    w_issueIdle;
    logic                    w_issueNext;
    logic [PC_WIDTH-1:0]     w_replayAddr;

    // Redirect outranks flush; either one empties the queue and kills the
    // reply of any outstanding request.
    assign w_redirect  = fi_bus.fi_change_pc;
    assign w_clear     = fi_bus.fi_change_pc || fi_bus.fi_i_flush;
    assign w_ack       = fi_bus.fi_i_ack;
    assign w_notEmpty  = (r_count != '0);
    assign w_push      = (r_state == REQ) && w_ack && !w_clear;
    assign w_pop       = w_notEmpty && !fi_bus.fi_i_stall;
    assign w_countNext = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // IDLE only starts a request when a slot is free right now; in REQ the
    // next request chains on an ack only if a slot is still free after this
    // cycle's push and pop. Neither issues on a redirect/flush cycle, so the
    // first request after one always uses the updated PC.
    assign w_issueIdle = (r_state == IDLE) && fi_bus.fi_i_ce && !w_clear && (r_count < DEPTH);
    assign w_issueNext = w_push && fi_bus.fi_i_ce && (w_countNext < DEPTH);

    // Restart address: redirect target, else the oldest instruction not yet
    // handed to decode, else the request still in flight, else the plain PC.
    always_comb begin
        w_replayAddr = r_pc;
        if (w_redirect) begin
            w_replayAddr = fi_bus.fi_alu_pc_value;
        end else if (w_notEmpty) begin
            w_replayAddr = PC_WIDTH'(r_addrMem[r_rdPtr]);
        end else if (r_state == REQ) begin
            w_replayAddr = PC_WIDTH'(r_reqAddr);
        end
    end

    // Request FSM: owns syn, the held request address and the PC.
    always_ff @(posedge fi_clk or posedge fi_rst) begin
        if (fi_rst) begin
            r_state   <= IDLE;
            r_syn     <= 1'b0;
            r_reqAddr <= '0;
            r_pc      <= RESET_PC;
        end else begin
            if (w_clear) begin
                r_pc <= w_replayAddr;
            end
            case (r_state)
                IDLE: begin
                    if (w_issueIdle) begin
                        r_state   <= REQ;
                        r_syn     <= 1'b1;
                        r_reqAddr <= r_pc[AWIDTH_INSTR-1:0];
                        r_pc      <= r_pc + PC_STEP;
                    end
                end
                REQ: begin
                    if (w_clear) begin
                        if (w_ack) begin
                            r_state <= IDLE;
                            r_syn   <= 1'b0;
                        end else begin
                            r_state <= DROP;
                        end
                    end else if (w_ack) begin
                        if (w_issueNext) begin
                            r_reqAddr <= r_pc[AWIDTH_INSTR-1:0];
                            r_pc      <= r_pc + PC_STEP;
                        end else begin
                            r_state <= IDLE;
                            r_syn   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (w_ack) begin
                        r_state <= IDLE;
                        r_syn   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_syn   <= 1'b0;
                end
            endcase
        end
    end

    // Queue bookkeeping: pointers wrap naturally because QDEPTH is a power
    // of two; a clear simply rewinds everything to empty.
    always_ff @(posedge fi_clk or posedge fi_rst) begin
        if (fi_rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= w_countNext;
        end
    end

    // Queue storage holds no reset; empty slots are masked at the output.
    always_ff @(posedge fi_clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= fi_bus.fi_i_instr;
            r_addrMem[r_wrPtr]  <= r_reqAddr;
        end
    end

    // One-cycle delayed copy of the flush request for downstream stages.
    always_ff @(posedge fi_clk or posedge fi_rst) begin
        if (fi_rst) begin
            r_flushDly <= 1'b0;
        end else begin
            r_flushDly <= fi_bus.fi_i_flush;
        end
    end

    assign fi_bus.fi_o_syn         = r_syn;
    assign fi_bus.fi_o_req_addr    = r_reqAddr;
    assign fi_bus.fi_o_ce          = w_notEmpty;
    assign fi_bus.fi_o_instr_fetch = w_notEmpty ? r_instrMem[r_rdPtr] : '0;
    assign fi_bus.fi_o_addr_instr  = w_notEmpty ? r_addrMem[r_rdPtr] : '0;
    assign fi_bus.fi_pc            = r_pc;
    assign fi_bus.fi_o_flush       = r_flushDly;
    assign fi_bus.fi_o_count       = r_count;
endmodule

// File: tb/tb_fetch_prefetch_q.sv
// Self-checking bench for fetch_prefetch_q: a table of cycle vectors for the
// zero-wait streaming/stall case, hand sequences for redirect, flush, wrap
// and reset, then random traffic against a queue-based reference model.
module tb_fetch_prefetch_q;
    localparam int          IW   = 32;
    localparam int          AW   = 32;
    localparam int          PW   = 32;
    localparam int          QD   = 4;
    localparam logic [31:0] RPC  = 32'h0;
    localparam logic [31:0] TAG  = 32'hA000_0000;

    logic clk;
    logic rst;

    fetch_prefetch_q_if #(.IWIDTH(IW), .AWIDTH_INSTR(AW), .PC_WIDTH(PW), .QDEPTH(QD)) bus ();

    fetch_prefetch_q #(
        .IWIDTH(IW), .AWIDTH_INSTR(AW), .PC_WIDTH(PW), .QDEPTH(QD), .RESET_PC(RPC)
    ) dut (
        .fi_clk(clk),
        .fi_rst(rst),
        .fi_bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Instruction memory: either a fixed-latency responder or a directly
    // driven ack; data is always TAG | requested address.
    logic manualAck;
    logic ackDrive;
    int   memLatency;
    int   memWait;

    assign bus.fi_i_ack   = manualAck ? ackDrive : (bus.fi_o_syn && (memWait >= memLatency));
    assign bus.fi_i_instr = TAG | bus.fi_o_req_addr;

    // Count cycles a request has waited without an ack.
    always @(posedge clk or posedge rst) begin
        if (rst) memWait <= 0;
        else if (bus.fi_o_syn && !bus.fi_i_ack) memWait <= memWait + 1;
        else memWait <= 0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic        stall;
        logic        expSyn;
        logic [31:0] expReqAddr;
        logic [31:0] expPc;
        int          expCount;
        logic [31:0] expHeadAddr;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    vec_t        vecs [14];
    entry_t      modelQ [$];
    logic        mBusy;
    logic        mDrop;
    logic [31:0] mReqAddr;
    logic [31:0] mPc;
    logic        mFlushOut;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        bus.fi_i_ce         = 1'b0;
        bus.fi_change_pc    = 1'b0;
        bus.fi_alu_pc_value = '0;
        bus.fi_i_flush      = 1'b0;
        bus.fi_i_stall      = 1'b0;
        manualAck           = 1'b0;
        ackDrive            = 1'b0;
        memLatency          = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        idleInputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkValue({tag, "_syn"},   32'(bus.fi_o_syn), 32'h0);
        checkValue({tag, "_raddr"}, bus.fi_o_req_addr, 32'h0);
        checkValue({tag, "_ce"},    32'(bus.fi_o_ce), 32'h0);
        checkValue({tag, "_instr"}, bus.fi_o_instr_fetch, 32'h0);
        checkValue({tag, "_haddr"}, bus.fi_o_addr_instr, 32'h0);
        checkValue({tag, "_pc"},    bus.fi_pc, RPC);
        checkValue({tag, "_oflush"}, 32'(bus.fi_o_flush), 32'h0);
        checkValue({tag, "_count"}, 32'(bus.fi_o_count), 32'h0);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.fi_i_ce    = v.ce;
        bus.fi_i_stall = v.stall;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string p;
        p = $sformatf("vec%0d", idx);
        checkValue({p, "_syn"},   32'(bus.fi_o_syn), 32'(v.expSyn));
        checkValue({p, "_raddr"}, bus.fi_o_req_addr, v.expReqAddr);
        checkValue({p, "_pc"},    bus.fi_pc, v.expPc);
        checkValue({p, "_count"}, 32'(bus.fi_o_count), 32'(v.expCount));
        checkValue({p, "_ce"},    32'(bus.fi_o_ce), 32'(v.expCount != 0));
        if (v.expCount != 0) begin
            checkValue({p, "_haddr"}, bus.fi_o_addr_instr, v.expHeadAddr);
            checkValue({p, "_instr"}, bus.fi_o_instr_fetch, TAG | v.expHeadAddr);
        end
    endtask

    task automatic checkModel(input int cyc);
        string p;
        p = $sformatf("rnd%0d", cyc);
        checkValue({p, "_syn"},    32'(bus.fi_o_syn), 32'(mBusy));
        checkValue({p, "_raddr"},  bus.fi_o_req_addr, mReqAddr);
        checkValue({p, "_pc"},     bus.fi_pc, mPc);
        checkValue({p, "_count"},  32'(bus.fi_o_count), 32'(modelQ.size()));
        checkValue({p, "_ce"},     32'(bus.fi_o_ce), 32'(modelQ.size() != 0));
        checkValue({p, "_oflush"}, 32'(bus.fi_o_flush), 32'(mFlushOut));
        if (modelQ.size() != 0) begin
            checkValue({p, "_haddr"}, bus.fi_o_addr_instr, modelQ[0].addr);
            checkValue({p, "_instr"}, bus.fi_o_instr_fetch, modelQ[0].instr);
        end
    endtask

    // Reference behaviour over one clock edge, from the inputs now applied.
    task automatic modelStep();
        int          sizeBefore;
        logic        redirect;
        logic        flush;
        logic        ack;
        logic        pop;
        logic [31:0] replay;
        entry_t      e;
        sizeBefore = modelQ.size();
        redirect   = bus.fi_change_pc;
        flush      = bus.fi_i_flush && !redirect;
        ack        = ackDrive;
        pop        = (sizeBefore > 0) && !bus.fi_i_stall;
        if (redirect || flush) begin
            if (redirect) replay = bus.fi_alu_pc_value;
            else if (sizeBefore > 0) replay = modelQ[0].addr;
            else if (mBusy && !mDrop) replay = mReqAddr;
            else replay = mPc;
            modelQ.delete();
            mPc = replay;
            if (mBusy) begin
                if (ack) begin
                    mBusy = 1'b0;
                    mDrop = 1'b0;
                end else begin
                    mDrop = 1'b1;
                end
            end
        end else if (mBusy && mDrop) begin
            if (ack) begin
                mBusy = 1'b0;
                mDrop = 1'b0;
            end
        end else if (mBusy) begin
            if (pop) void'(modelQ.pop_front());
            if (ack) begin
                e.instr = TAG | mReqAddr;
                e.addr  = mReqAddr;
                modelQ.push_back(e);
                if (bus.fi_i_ce && modelQ.size() < QD) begin
                    mReqAddr = mPc;
                    mPc      = mPc + 32'd4;
                end else begin
                    mBusy = 1'b0;
                end
            end
        end else begin
            if (pop) void'(modelQ.pop_front());
            if (bus.fi_i_ce && sizeBefore < QD) begin
                mBusy    = 1'b1;
                mReqAddr = mPc;
                mPc      = mPc + 32'd4;
            end
        end
        mFlushOut = bus.fi_i_flush;
    endtask

    initial begin
        // Zero-wait memory: stall fills the queue, release drains it in
        // order while fetching resumes, then ce low lets it run dry.
        //          ce    stall syn   reqAddr  pc      cnt head
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 32'h04, 0, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 32'h08, 1, 32'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 32'h0C, 2, 32'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 32'h10, 3, 32'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0C, 32'h10, 4, 32'h00};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0C, 32'h10, 4, 32'h00};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h0C, 32'h10, 3, 32'h04};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h10, 32'h14, 2, 32'h08};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h14, 32'h18, 2, 32'h0C};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h18, 32'h1C, 2, 32'h10};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h1C, 32'h20, 2, 32'h14};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h1C, 32'h20, 2, 32'h18};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h1C, 32'h20, 1, 32'h1C};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h1C, 32'h20, 0, 32'h00};

        rst = 1'b1;
        idleInputs();
        #1;
        checkResetOutputs("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput(vecs[i], i);
        end

        // Redirect while a 3-cycle request is in flight: its data is dropped.
        doReset();
        memLatency = 3;
        bus.fi_i_ce = 1'b1;
        tick();
        checkValue("rdA_syn", 32'(bus.fi_o_syn), 32'h1);
        checkValue("rdA_raddr", bus.fi_o_req_addr, 32'h0);
        bus.fi_change_pc    = 1'b1;
        bus.fi_alu_pc_value = 32'h100;
        tick();
        bus.fi_change_pc = 1'b0;
        checkValue("rdA_pc", bus.fi_pc, 32'h100);
        checkValue("rdA_hold_syn", 32'(bus.fi_o_syn), 32'h1);
        checkValue("rdA_hold_raddr", bus.fi_o_req_addr, 32'h0);
        tick();
        tick();
        checkValue("rdA_ackcyc_syn", 32'(bus.fi_o_syn), 32'h1);
        checkValue("rdA_ackcyc_raddr", bus.fi_o_req_addr, 32'h0);
        tick();
        checkValue("rdA_idle_syn", 32'(bus.fi_o_syn), 32'h0);
        checkValue("rdA_idle_count", 32'(bus.fi_o_count), 32'h0);
        tick();
        checkValue("rdA_new_syn", 32'(bus.fi_o_syn), 32'h1);
        checkValue("rdA_new_raddr", bus.fi_o_req_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkValue($sformatf("rdA_wait%0d_ce", i), 32'(bus.fi_o_ce), 32'h0);
        end
        tick();
        checkValue("rdA_head_ce", 32'(bus.fi_o_ce), 32'h1);
        checkValue("rdA_head_instr", bus.fi_o_instr_fetch, 32'hA000_0100);
        checkValue("rdA_head_addr", bus.fi_o_addr_instr, 32'h100);

        // Redirect in the same cycle as the ack.
        doReset();
        memLatency = 1;
        bus.fi_i_ce = 1'b1;
        tick();
        tick();
        checkValue("rdB_ack", 32'(bus.fi_i_ack), 32'h1);
        bus.fi_change_pc    = 1'b1;
        bus.fi_alu_pc_value = 32'h200;
        tick();
        bus.fi_change_pc = 1'b0;
        checkValue("rdB_count", 32'(bus.fi_o_count), 32'h0);
        checkValue("rdB_ce", 32'(bus.fi_o_ce), 32'h0);
        checkValue("rdB_syn", 32'(bus.fi_o_syn), 32'h0);
        checkValue("rdB_pc", bus.fi_pc, 32'h200);
        tick();
        checkValue("rdB_new_syn", 32'(bus.fi_o_syn), 32'h1);
        checkValue("rdB_new_raddr", bus.fi_o_req_addr, 32'h200);
        checkValue("rdB_new_pc", bus.fi_pc, 32'h204);

        // PC wraps modulo 2^PC_WIDTH.
        doReset();
        bus.fi_change_pc    = 1'b1;
        bus.fi_alu_pc_value = 32'hFFFF_FFFC;
        tick();
        bus.fi_change_pc = 1'b0;
        bus.fi_i_ce      = 1'b1;
        tick();
        checkValue("wrap_raddr", bus.fi_o_req_addr, 32'hFFFF_FFFC);
        checkValue("wrap_pc", bus.fi_pc, 32'h0);

        // Flush with 0x20,0x24 queued and 0x28 outstanding replays from 0x20.
        doReset();
        manualAck = 1'b1;
        bus.fi_change_pc    = 1'b1;
        bus.fi_alu_pc_value = 32'h20;
        tick();
        bus.fi_change_pc = 1'b0;
        bus.fi_i_ce      = 1'b1;
        bus.fi_i_stall   = 1'b1;
        tick();
        ackDrive = 1'b1;
        tick();
        tick();
        ackDrive = 1'b0;
        checkValue("fl_pre_count", 32'(bus.fi_o_count), 32'h2);
        checkValue("fl_pre_head", bus.fi_o_addr_instr, 32'h20);
        checkValue("fl_pre_raddr", bus.fi_o_req_addr, 32'h28);
        bus.fi_i_flush = 1'b1;
        tick();
        bus.fi_i_flush = 1'b0;
        checkValue("fl_count", 32'(bus.fi_o_count), 32'h0);
        checkValue("fl_ce", 32'(bus.fi_o_ce), 32'h0);
        checkValue("fl_pc", bus.fi_pc, 32'h20);
        checkValue("fl_oflush", 32'(bus.fi_o_flush), 32'h1);
        checkValue("fl_hold_syn", 32'(bus.fi_o_syn), 32'h1);
        ackDrive = 1'b1;
        tick();
        ackDrive = 1'b0;
        checkValue("fl_oflush_low", 32'(bus.fi_o_flush), 32'h0);
        checkValue("fl_drop_syn", 32'(bus.fi_o_syn), 32'h0);
        checkValue("fl_drop_count", 32'(bus.fi_o_count), 32'h0);
        tick();
        checkValue("fl_re_raddr", bus.fi_o_req_addr, 32'h20);
        checkValue("fl_re_pc", bus.fi_pc, 32'h24);
        bus.fi_i_stall = 1'b0;
        ackDrive = 1'b1;
        tick();
        ackDrive = 1'b0;
        checkValue("fl_re_instr", bus.fi_o_instr_fetch, 32'hA000_0020);
        checkValue("fl_re_raddr2", bus.fi_o_req_addr, 32'h24);

        // Reset asserted mid-request takes effect without a clock edge.
        checkValue("rst_pre_syn", 32'(bus.fi_o_syn), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("rstmid");
        @(negedge clk);
        idleInputs();
        rst = 1'b0;
        bus.fi_i_ce = 1'b1;
        tick();
        checkValue("rst_re_syn", 32'(bus.fi_o_syn), 32'h1);
        checkValue("rst_re_raddr", bus.fi_o_req_addr, RPC);
        checkValue("rst_re_pc", bus.fi_pc, RPC + 32'd4);

        // Random traffic against the reference model.
        doReset();
        manualAck = 1'b1;
        mBusy     = 1'b0;
        mDrop     = 1'b0;
        mReqAddr  = 32'h0;
        mPc       = RPC;
        mFlushOut = 1'b0;
        modelQ.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            checkModel(cyc);
            bus.fi_i_ce         = ($urandom_range(0, 9) < 8);
            bus.fi_i_stall      = ($urandom_range(0, 9) < 3);
            bus.fi_change_pc    = ($urandom_range(0, 19) == 0);
            bus.fi_i_flush      = ($urandom_range(0, 19) == 0);
            bus.fi_alu_pc_value = 32'($urandom_range(0, 255)) << 2;
            ackDrive            = mBusy && ($urandom_range(0, 1) == 1);
            modelStep();
            tick();
        end
        checkModel(1500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_prefetch_q.md
Name: fetch_prefetch_q

Overview:
- Parametrised successor fetch stage: PC generator plus syn/ack instruction-memory master plus QDEPTH-entry prefetch queue.
- Decouples variable-latency instruction memory from decode.
- Supports branch redirect and pipeline flush with replay.
- Sits between instruction memory and the decode stage; presents instruction, its address and a valid (ce) flag downstream.

Parameters:
IWIDTH, 32, instruction width in bits (multiple of 8)
AWIDTH_INSTR, 32, instruction-memory address width
PC_WIDTH, 32, PC width (>= AWIDTH_INSTR)
QDEPTH, 4, prefetch queue entries (power of 2, >= 2)
RESET_PC, 0, first fetch address after reset

Ports:
fi_clk  in  1  clock, rising edge
fi_rst  in  1  asynchronous active-high reset
fi_i_ce  in  1  fetch enable; low blocks issue of new requests
fi_change_pc  in  1  redirect request
fi_alu_pc_value  in  PC_WIDTH  redirect target
fi_i_flush  in  1  flush queue, replay from oldest undelivered address
fi_i_stall  in  1  decode not ready; blocks pop
fi_o_syn  out  1  memory request valid
fi_o_req_addr  out  AWIDTH_INSTR  memory request address
fi_i_ack  in  1  memory completion; fi_i_instr valid this cycle
fi_i_instr  in  IWIDTH  returned instruction
fi_o_instr_fetch  out  IWIDTH  queue head instruction
fi_o_addr_instr  out  AWIDTH_INSTR  queue head address
fi_o_ce  out  1  head valid (queue non-empty)
fi_pc  out  PC_WIDTH  next address to be requested
fi_o_flush  out  1  fi_i_flush delayed one cycle
fi_o_count  out  clog2(QDEPTH)+1  queue occupancy

Behaviour:
- Reset (async, immediate):
  - fi_o_syn=0, fi_o_req_addr=0, fi_o_ce=0, fi_o_instr_fetch=0, fi_o_addr_instr=0.
  - fi_pc=RESET_PC, fi_o_flush=0, fi_o_count=0, FSM=IDLE, queue empty.
  - Reset mid-request abandons it; memory must tolerate a dropped syn.
- PC step: IWIDTH/8 bytes; additions wrap modulo 2^PC_WIDTH. Request address = fi_pc[AWIDTH_INSTR-1:0].
- FSM states IDLE, REQ, DROP:
  - IDLE -> REQ when fi_i_ce && (count + 0) < QDEPTH, i.e. a free slot is reserved. Next edge: fi_o_syn=1, fi_o_req_addr=fi_pc, fi_pc += step.
  - REQ: syn and address held stable until fi_i_ack.
    - On ack: push {fi_i_instr, addr}.
    - If fi_i_ce && a slot remains (count after this cycle's push/pop < QDEPTH), issue the next request back-to-back (stay REQ, new address); else go to IDLE with syn=0.
  - REQ + redirect/flush without ack -> DROP; syn/address stay held.
  - REQ + redirect/flush with ack same cycle: data discarded, go to IDLE.
  - DROP: wait for ack, discard data, go to IDLE. A further redirect in DROP only updates fi_pc.
- Queue:
  - Push only from REQ on ack; pop when fi_o_ce && !fi_i_stall.
  - Simultaneous push/pop keeps count.
  - Slot reservation guarantees no push when full. Pop on empty is ignored.
  - Head outputs are combinational from the read pointer.
  - Pointers wrap modulo QDEPTH.
- Redirect (fi_change_pc=1), effective next edge:
  - Queue cleared (count=0, fi_o_ce=0).
  - fi_pc = fi_alu_pc_value.
  - In-flight request dropped as above.
  - First new request issues no earlier than the cycle after IDLE is reached.
- Flush (fi_i_flush=1, no redirect):
  - Replay address = head addr if queue non-empty, else outstanding request address if in REQ, else fi_pc.
  - fi_pc = replay address; queue cleared; in-flight handled as for redirect.
- Priority: fi_rst > fi_change_pc > fi_i_flush > normal.
- fi_o_flush: registered copy of fi_i_flush.
- fi_i_ce low: no new issue; pending request completes and pushes; pops continue.

Test Plan:
- Reset, then ce=1 with a 0-wait memory (ack same cycle as syn, instr=0xA000_0000|addr) and stall=0 -> requests 0x0,0x4,0x8… back-to-back; fi_o_instr_fetch sequence A0000000, A0000004…; fi_o_addr_instr matches.
- stall=1 with QDEPTH=4 -> exactly 4 acks accepted, fi_o_count=4, fi_o_syn low. Release stall -> pops in order, fetching resumes at 0x10.
- Memory with 3-cycle ack latency, redirect to 0x100 one cycle after syn rises -> syn/addr held until ack, data never appears at output, next request addr 0x100, first output instr A0000100.
- Redirect and ack in same cycle -> returned data dropped, fi_o_count=0 next cycle, fi_pc=target.
- Queue holding 0x20,0x24 with request 0x28 outstanding, pulse fi_i_flush -> queue empty, fi_o_flush high one cycle later, refetch starts at 0x20.
- Assert fi_rst while in REQ -> all outputs zero/RESET_PC immediately, without waiting for the clock edge; ce=1 after release restarts fetch at RESET_PC.
